// File: rtl/cpu_mac_ci.sv
// Multi-cycle multiply-accumulate custom instruction.
// Computes the low 32 bits of dataa*datab from three 16x16 partial products
// and folds the product into a wide unsigned accumulator that software
// reads back as two 32-bit words (RDLO / RDHI).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operands and opcode sampled here
// MUL   | MAC only: partial products combined into the 32-bit product
// ACC   | opcode commits: accumulate, clear, or capture a read-back word
// RESP  | done high for one cycle; result holds the instruction result
//
// CLR/RDLO/RDHI spend one cycle in ACC so every opcode commits on the edge
// into RESP; that gives done at T+2 for those and T+3 for MAC.
module cpu_mac_ci #(
  parameter int ACC_W    = 48,
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_CLR  = 2'd0;
  localparam logic [1:0] OP_MAC  = 2'd1;
  localparam logic [1:0] OP_RDLO = 2'd2;
  localparam logic [1:0] OP_RDHI = 2'd3;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       p_ll_q, p_ll_d;
  logic [15:0]       p_hl_q, p_hl_d;
  logic [15:0]       p_lh_q, p_lh_d;
  logic [31:0]       prod_q, prod_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       result_q, result_d;

  logic [15:0]       cross_sum;
  logic [ACC_W:0]    sum;
  logic [31:0]       rdhi_word;

  // Only the low 16 bits of the cross terms reach the low 32 of the product.
  assign cross_sum = p_hl_q + p_lh_q;
  assign sum       = {1'b0, acc_q} + {{(ACC_W-31){1'b0}}, prod_q};

  // High read-back word: overflow flag on top, upper accumulator bits below.
  always_comb begin
    rdhi_word                = '0;
    rdhi_word[ACC_W-33:0]    = acc_q[ACC_W-1:32];
    rdhi_word[31]            = ovf_q;
  end

  // Next-state and datapath updates for the instruction sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    p_ll_d   = p_ll_q;
    p_hl_d   = p_hl_q;
    p_lh_d   = p_lh_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = n;
          if (n == OP_MAC) begin
            p_ll_d  = {16'h0, dataa[15:0]} * {16'h0, datab[15:0]};
            p_hl_d  = dataa[31:16] * datab[15:0];
            p_lh_d  = dataa[15:0]  * datab[31:16];
            state_d = MUL;
          end else begin
            state_d = ACC;
          end
        end
      end
      MUL: begin
        prod_d  = p_ll_q + {cross_sum, 16'h0};
        state_d = ACC;
      end
      ACC: begin
        case (op_q)
          OP_CLR: begin
            acc_d    = '0;
            ovf_d    = 1'b0;
            result_d = '0;
          end
          OP_MAC: begin
            if (sum[ACC_W]) ovf_d = 1'b1;
            if (sum[ACC_W] && SATURATE) acc_d = '1;
            else                        acc_d = sum[ACC_W-1:0];
            result_d = prod_q;
          end
          OP_RDLO: result_d = acc_q[31:0];
          OP_RDHI: result_d = rdhi_word;
        endcase
        state_d = RESP;
      end
      RESP: state_d = IDLE;
    endcase
  end

  // Register bank: reset wins, otherwise everything freezes with clk_en low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_CLR;
      p_ll_q   <= '0;
      p_hl_q   <= '0;
      p_lh_q   <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      op_q     <= op_d;
      p_ll_q   <= p_ll_d;
      p_hl_q   <= p_hl_d;
      p_lh_q   <= p_lh_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign done   = (state_q == RESP);
  assign result = result_q;

endmodule
